// File: rtl/minterm_scanner_if.sv
// Minterm index stream from the scanner to its consumer.
interface minterm_scanner_if #(
    parameter int N_VARS = 3
);
    // Valid/ready: a transfer happens on a rising clk edge where m_valid && m_ready;
    // while m_valid is high and m_ready is low, m_index and m_last stay unchanged.
    logic              m_valid;
    logic [N_VARS-1:0] m_index;
    logic              m_last;
    logic              m_ready;

    modport master (output m_valid, output m_index, output m_last, input m_ready);
    modport slave  (input m_valid, input m_index, input m_last, output m_ready);
endinterface

// File: rtl/minterm_scanner.sv
// Drives every input combination onto an external function, captures its truth
// table, then streams the indices of the true minterms in ascending order.
module minterm_scanner #(
    parameter int N_VARS = 3,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     f_in,
    output logic [N_VARS-1:0]        vars,
    output logic                     busy,
    output logic [(1<<N_VARS)-1:0]   truth_table,
    minterm_scanner_if.master        m_if,
    output logic [N_VARS:0]          count,
    output logic                     done,
    output logic [1:0]               o_dbg_state
);
    localparam int TT_W = 1 << N_VARS;
    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE - 1);
    localparam logic [SC_W-1:0]   SC_ONE      = SC_W'(1);
    localparam logic [N_VARS-1:0] VARS_ONE    = N_VARS'(1);
    localparam logic [TT_W-1:0]   TT_ONE      = TT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [N_VARS-1:0]   r_vars;
    logic [TT_W-1:0]     r_tt;
    logic [N_VARS:0]     r_count;
    logic [SC_W-1:0]     r_settle;
    logic [TT_W-1:0]     r_pending;
    logic                r_m_valid;
    logic [N_VARS-1:0]   r_m_index;
    logic                r_m_last;
    logic                r_done;
    logic                r_busy;

    logic [TT_W-1:0]     w_tt_sampled;
    logic [TT_W-1:0]     w_pending_clr;
    logic [TT_W-1:0]     w_pending_next;
    logic                w_sample;
    logic                w_accept;

    function automatic logic [N_VARS-1:0] lowest_index(input logic [TT_W-1:0] p);
        lowest_index = '0;
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (p[i]) lowest_index = N_VARS'(i);
        end
    endfunction

    function automatic logic single_bit(input logic [TT_W-1:0] p);
        single_bit = (p != '0) && ((p & (p - TT_ONE)) == '0);
    endfunction

    always_comb begin
        w_tt_sampled         = r_tt;
        w_tt_sampled[r_vars] = f_in;
        w_sample             = (r_settle == SETTLE_LAST);
        w_accept             = r_m_valid && m_if.m_ready;
        // The presented index is always the lowest pending bit, so clearing it is p & (p-1).
        w_pending_clr        = r_pending & (r_pending - TT_ONE);
        w_pending_next       = w_accept ? w_pending_clr : r_pending;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_vars    <= '0;
            r_tt      <= '0;
            r_count   <= '0;
            r_settle  <= '0;
            r_pending <= '0;
            r_m_valid <= 1'b0;
            r_m_index <= '0;
            r_m_last  <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tt     <= '0;
                        r_count  <= '0;
                        r_vars   <= '0;
                        r_settle <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (w_sample) begin
                        r_tt     <= w_tt_sampled;
                        r_count  <= r_count + {{N_VARS{1'b0}}, f_in};
                        r_settle <= '0;
                        if (&r_vars) begin
                            r_state   <= S_EMIT;
                            r_pending <= w_tt_sampled;
                            r_m_valid <= |w_tt_sampled;
                            r_m_index <= lowest_index(w_tt_sampled);
                            r_m_last  <= single_bit(w_tt_sampled);
                        end else begin
                            r_vars <= r_vars + VARS_ONE;
                        end
                    end else begin
                        r_settle <= r_settle + SC_ONE;
                    end
                end
                S_EMIT: begin
                    if (w_pending_next == '0) begin
                        r_state   <= S_DONE;
                        r_pending <= '0;
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (w_accept) begin
                        r_pending <= w_pending_clr;
                        r_m_valid <= 1'b1;
                        r_m_index <= lowest_index(w_pending_clr);
                        r_m_last  <= single_bit(w_pending_clr);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign vars           = r_vars;
    assign busy           = r_busy;
    assign truth_table    = r_tt;
    assign count          = r_count;
    assign done           = r_done;
    assign o_dbg_state    = r_state;
    assign m_if.m_valid   = r_m_valid;
    assign m_if.m_index   = r_m_index;
    assign m_if.m_last    = r_m_last;
endmodule

// File: tb/tb_minterm_scanner.sv
// Self-checking bench for minterm_scanner: one SETTLE=1 and one SETTLE=3 instance.
module tb_minterm_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic m_ready = 1'b1;
  logic glitch = 1'b0;
  int sel = 0;
  int fmode = 0;
  int ready_mode = 0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [7:0] cur_exp_tt;
  int cur_exp_cnt;
  logic [3:0] exp_q[$];
  logic [3:0] rpat = 4'b1001;

  always #5 clk = ~clk;

  minterm_scanner_if #(.N_VARS(3)) if_a ();
  minterm_scanner_if #(.N_VARS(3)) if_b ();

  logic start_a, start_b, f_a, f_b, busy_a, busy_b, done_a, done_b;
  logic [2:0] vars_a, vars_b;
  logic [7:0] tt_a, tt_b;
  logic [3:0] cnt_a, cnt_b;
  logic [1:0] st_a, st_b;

  function automatic logic f_func(input int mode, input logic [2:0] v);
    case (mode)
      0: return v[2] | (v[1] & ~v[0]);
      1: return 1'b0;
      2: return 1'b1;
      default: return ^v;
    endcase
  endfunction

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel != 0);
  assign f_a = f_func(fmode, vars_a) ^ glitch;
  assign f_b = f_func(fmode, vars_b) ^ glitch;
  assign if_a.m_ready = m_ready;
  assign if_b.m_ready = m_ready;

  minterm_scanner #(.N_VARS(3), .SETTLE(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .f_in(f_a), .vars(vars_a),
    .busy(busy_a), .truth_table(tt_a), .m_if(if_a), .count(cnt_a),
    .done(done_a), .o_dbg_state(st_a));

  minterm_scanner #(.N_VARS(3), .SETTLE(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .f_in(f_b), .vars(vars_b),
    .busy(busy_b), .truth_table(tt_b), .m_if(if_b), .count(cnt_b),
    .done(done_b), .o_dbg_state(st_b));

  logic w_valid, w_last, w_done, w_busy;
  logic [2:0] w_idx, w_vars;
  logic [7:0] w_tt;
  logic [3:0] w_cnt;
  assign w_valid = (sel != 0) ? if_b.m_valid : if_a.m_valid;
  assign w_last  = (sel != 0) ? if_b.m_last  : if_a.m_last;
  assign w_idx   = (sel != 0) ? if_b.m_index : if_a.m_index;
  assign w_done  = (sel != 0) ? done_b : done_a;
  assign w_busy  = (sel != 0) ? busy_b : busy_a;
  assign w_vars  = (sel != 0) ? vars_b : vars_a;
  assign w_tt    = (sel != 0) ? tt_b : tt_a;
  assign w_cnt   = (sel != 0) ? cnt_b : cnt_a;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // m_ready pattern changes just after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    m_ready = (ready_mode == 0) ? 1'b1 : rpat[cyc % 4];
  end

  // Monitor: pops the expected queue on every handshake, checks hold-while-stalled and done results.
  logic prev_stall = 1'b0;
  logic [2:0] prev_idx;
  logic prev_last;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (w_valid) begin
        if (prev_stall) begin
          chk("stall_hold_index", w_idx, prev_idx);
          chk("stall_hold_last", w_last, prev_last);
        end
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_index", w_idx, -1);
          end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            chk("m_index", w_idx, e[2:0]);
            chk("m_last", w_last, e[3]);
          end
        end
        prev_stall = !m_ready;
        prev_idx = w_idx;
        prev_last = w_last;
      end else begin
        if (prev_stall) chk("dropped_while_stalled", 0, 1);
        prev_stall = 1'b0;
      end
      if (w_done) begin
        done_cnt++;
        chk("done_truth_table", w_tt, cur_exp_tt);
        chk("done_count", w_cnt, cur_exp_cnt);
        chk("done_queue_empty", exp_q.size(), 0);
      end
    end
  end

  task automatic load_exp(input logic [7:0] tt, input int cnt);
    logic [7:0] above;
    exp_q.delete();
    cur_exp_tt = tt;
    cur_exp_cnt = cnt;
    for (int i = 0; i < 8; i++) begin
      above = tt >> (i + 1);
      if (tt[i]) exp_q.push_back({(above == 8'd0), i[2:0]});
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vars"}, w_vars, 0);
    chk({tag, "_truth_table"}, w_tt, 0);
    chk({tag, "_count"}, w_cnt, 0);
    chk({tag, "_m_valid"}, w_valid, 0);
    chk({tag, "_m_last"}, w_last, 0);
    chk({tag, "_done"}, w_done, 0);
    chk({tag, "_busy"}, w_busy, 0);
  endtask

  task automatic pulse_start(output int start_cyc);
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!w_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("done_timeout", 0, 1);
  endtask

  task automatic run_scan(input int s, input int mode, input int rmode,
                          input logic [7:0] exp_tt, input int exp_cnt, input int exp_lat);
    int st, n, sw;
    sel = s;
    fmode = mode;
    ready_mode = rmode;
    sw = (s != 0) ? 3 : 1;
    load_exp(exp_tt, exp_cnt);
    pulse_start(st);
    chk("busy_after_start", w_busy, 1);
    for (int j = 0; j < 8 * sw; j++) begin
      glitch = (sw > 1) && ((j % sw) != (sw - 1));
      chk("vars_step", w_vars, j / sw);
      @(negedge clk);
    end
    glitch = 1'b0;
    wait_done(n);
    if (exp_lat > 0) chk("scan_latency", cyc - st, exp_lat);
    @(negedge clk);
    chk("done_one_cycle", w_done, 0);
    chk("idle_after_done", w_busy, 0);
  endtask

  initial begin
    int st, n, d0;
    repeat (3) @(negedge clk);
    sel = 0;
    check_zero("reset_a");
    sel = 1;
    check_zero("reset_b");
    #2 reset = 1'b0;

    // f = a | (b & ~c), full throughput
    run_scan(0, 0, 0, 8'b1111_0100, 5, 13);
    // same function with a stalling consumer
    run_scan(0, 0, 1, 8'b1111_0100, 5, 0);
    // constant 0 and constant 1
    run_scan(0, 1, 0, 8'b0000_0000, 0, 9);
    run_scan(0, 2, 0, 8'b1111_1111, 8, 16);
    // XOR with SETTLE=3 and glitches on non-sample cycles
    run_scan(1, 3, 0, 8'b1001_0110, 4, 28);

    // reset mid-DRIVE at vars=5
    sel = 0; fmode = 0; ready_mode = 0;
    load_exp(8'b1111_0100, 5);
    pulse_start(st);
    n = 0;
    while (w_vars != 3'd5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vars5", (n < 50) ? 1 : 0, 1);
    #2 reset = 1'b1;
    exp_q.delete();
    #1 check_zero("abort_drive");
    @(negedge clk);
    #2 reset = 1'b0;

    // reset mid-EMIT
    load_exp(8'b1111_0100, 5);
    pulse_start(st);
    n = 0;
    while (!w_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_emit", (n < 50) ? 1 : 0, 1);
    #2 reset = 1'b1;
    exp_q.delete();
    #1 check_zero("abort_emit");
    @(negedge clk);
    #2 reset = 1'b0;
    run_scan(0, 0, 0, 8'b1111_0100, 5, 13);

    // start pulses while busy are ignored
    ready_mode = 1;
    load_exp(8'b1111_0100, 5);
    d0 = done_cnt;
    pulse_start(st);
    n = 0;
    while (w_vars != 3'd3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!w_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    repeat (6) @(negedge clk);
    chk("one_done_per_start", done_cnt - d0, 1);
    chk("idle_after_ignored_starts", w_busy, 0);
    chk("results_held_in_idle", w_cnt, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end
endmodule
